line_frame_sequencer: RTL and testbench
=======================================

Name: line_frame_sequencer

Overview:
- Frame controller for the line-sensor front end.
- Each frame runs exposure (with laser pulse inside it), then pixel readout, then an inter-frame gap.
- Generates the sensor clock, the ADC clock and the data-valid window that gate the 10-bit pixel stream into the centroid datapath.
- Sits between the UART config registers and the sensor/ADC pins; its data_valid drives ADC_CLAMP at top level.

Parameters:
- PIXELS, 512, pixels read per frame; pixel_addr width is clog2(PIXELS).
- PIX_DIV, 4, clk cycles per pixel period; even, minimum 2.
- GAP_CYCLES, 16, idle clk cycles between readout end and next exposure.
- LEN_W, 16, width of the exposure/laser length inputs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  continuous frame mode; sampled in IDLE and at end of GAP
- exposure_len  in  LEN_W  exposure length in clk cycles; latched at frame start
- laser_len  in  LEN_W  laser pulse length in clk cycles; latched at frame start
- sens_clk  out  1  sensor pixel clock
- adc_clk  out  1  ADC sample clock
- exposure  out  1  sensor exposure/integration gate
- laser  out  1  laser drive enable
- data_valid  out  1  pixel data window (to ADC_CLAMP / centroid)
- pixel_addr  out  clog2(PIXELS)  index of the current pixel
- frame_start  out  1  1-cycle pulse on entry to EXPOSE
- frame_done  out  1  1-cycle pulse on the last READOUT cycle
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; pixel_addr 0; latched lengths 0.
- Reset mid-frame: outputs drop to 0 immediately, with no frame_done pulse.
- All outputs are registered.
- IDLE -> EXPOSE when enable=1. On that edge:
  - latch exp_q = max(exposure_len,1) and las_q = laser_len;
  - frame_start=1 for the first EXPOSE cycle.
- EXPOSE:
  - exposure=1 for exactly exp_q cycles; down-counter of LEN_W bits.
  - laser=1 from the first EXPOSE cycle for min(las_q,exp_q) cycles; las_q=0 means laser is never asserted.
  - laser never extends past exposure.
  - Exits to READOUT after the exp_q-th cycle.
- READOUT: PIXELS*PIX_DIV cycles; phase counter p = 0..PIX_DIV-1, restarted at entry.
  - sens_clk=1 for p < PIX_DIV/2, else 0.
  - adc_clk = registered complement of sens_clk; high only during READOUT.
  - data_valid=1 throughout READOUT.
  - pixel_addr starts at 0 and increments at each p wrap; it saturates at PIXELS-1 and never wraps inside a frame.
  - frame_done=1 on the final cycle (pixel PIXELS-1, p=PIX_DIV-1).
  - Next state is GAP.
- GAP: all pin outputs 0 for GAP_CYCLES cycles, then:
  - enable=1 -> EXPOSE (new frame, new latch);
  - enable=0 -> IDLE.
- Lowering enable mid-frame does not abort the frame; the frame completes through GAP.
- Changing exposure_len/laser_len mid-frame has no effect until the next frame latch.
- Between frames, pixel_addr returns to 0 on READOUT entry.
- busy=0 only in IDLE.

Decomposition:
- Shared package (sensor_pkg):
  - state enum {IDLE, EXPOSE, READOUT, GAP};
  - default PIXELS and PIX_DIV constants, so the centroid block and the test bench agree on the frame size.
- One natural sub-module: pixel_clock_gen (phase counter, sens_clk/adc_clk generation, pixel advance strobe, pixel_addr counter), enabled only in READOUT.

Test Plan:
- Single frame with PIX_DIV=4, PIXELS=512, exposure_len=100, laser_len=40, enable pulsed 1 cycle:
  - exposure high exactly 100 cycles and laser high exactly 40 from the same edge;
  - data_valid high 2048 cycles with 512 sens_clk rising edges;
  - frame_done once; returns to IDLE after 16 GAP cycles.
- laser_len=300 with exposure_len=100 -> laser high 100 cycles, ending on the same edge as exposure. laser_len=0 -> laser never high.
- exposure_len=0 -> exposure high exactly 1 cycle, then normal readout.
- Continuous enable=1 over 3 frames:
  - frame_start spacing = exp_q + 2048 + 16 cycles;
  - exposure_len changed during frame 1 takes effect in frame 2 only.
- Reset asserted mid-READOUT at pixel 200:
  - all outputs 0 asynchronously, no frame_done;
  - after release with enable=1, frame restarts with pixel_addr 0.
- Pixel stream check: inject 500/800/500 at pixels 101-103 keyed on data_valid and pixel_addr. The captured values at pixel_addr 101..103 match, and no data_valid appears outside READOUT.

Source files
------------

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared frame-geometry constants and sequencer state encoding
// Contents:
//   state_t          frame sequencer states
//   PIXELS_DEF       pixels read out per frame (shared with centroid block and bench)
//   PIX_DIV_DEF      clk cycles per pixel period
//   GAP_CYCLES_DEF   idle clk cycles between readout end and next exposure
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int PIXELS_DEF     = 512;
    localparam int PIX_DIV_DEF    = 4;
    localparam int GAP_CYCLES_DEF = 16;

endpackage

// File: rtl/pixel_clock_gen.sv
// rtl/pixel_clock_gen.sv - readout phase counter, sensor/ADC clocks and pixel address
// Ports:
//   clk, reset   system clock, async active-high reset
//   run_d        sequencer will be in READOUT next cycle (all outputs are registered)
//   sens_clk     high for the first half of each pixel period
//   adc_clk      complement of sens_clk, high only during readout
//   pixel_addr   current pixel, 0 at readout entry, saturates at PIXELS-1
//   frame_last   high on the final readout cycle (last pixel, last phase)
module pixel_clock_gen
    import sensor_pkg::*;
#(
    parameter int PIXELS  = PIXELS_DEF,
    parameter int PIX_DIV = PIX_DIV_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_d,
    output logic                      sens_clk,
    output logic                      adc_clk,
    output logic [$clog2(PIXELS)-1:0] pixel_addr,
    output logic                      frame_last
);

    localparam int ADDR_W = $clog2(PIXELS);
    localparam int PH_W   = $clog2(PIX_DIV);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PIX_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(PIX_DIV / 2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);

    logic [PH_W-1:0]   phase_q;
    logic [PH_W-1:0]   phase_n;
    logic [ADDR_W-1:0] addr_n;
    logic              running_q;
    logic              pix_adv;
    logic              sens_n;

    // Next phase/address are computed from the upcoming cycle so that the
    // registered clocks line up with the first READOUT cycle.
    always_comb begin
        phase_n = phase_q;
        addr_n  = pixel_addr;
        pix_adv = 1'b0;
        if (run_d) begin
            if (!running_q) begin
                phase_n = '0;
                addr_n  = '0;
            end else if (phase_q == PH_LAST) begin
                phase_n = '0;
                pix_adv = 1'b1;
            end else begin
                phase_n = phase_q + PH_W'(1);
            end
            if (pix_adv && (pixel_addr != ADDR_LAST)) begin
                addr_n = pixel_addr + ADDR_W'(1);
            end
        end
    end

    assign sens_n = run_d && (phase_n < PH_HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= '0;
            running_q  <= 1'b0;
            pixel_addr <= '0;
            sens_clk   <= 1'b0;
            adc_clk    <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            phase_q    <= phase_n;
            running_q  <= run_d;
            pixel_addr <= addr_n;
            sens_clk   <= sens_n;
            adc_clk    <= run_d && !sens_n;
            frame_last <= run_d && (phase_n == PH_LAST) && (addr_n == ADDR_LAST);
        end
    end

endmodule

// File: rtl/line_frame_sequencer.sv
// rtl/line_frame_sequencer.sv - line-sensor frame controller: exposure, laser, readout, gap
// Ports:
//   clk, reset            system clock, async active-high reset
//   enable                continuous frame mode, sampled in IDLE and at end of GAP
//   exposure_len          exposure length in clk cycles (0 treated as 1), latched at frame start
//   laser_len             laser pulse length in clk cycles, latched at frame start
//   sens_clk, adc_clk     sensor pixel clock / ADC sample clock, READOUT only
//   exposure, laser       integration gate / laser drive, laser confined inside exposure
//   data_valid            pixel data window, high throughout READOUT
//   pixel_addr            index of the current pixel
//   frame_start           1-cycle pulse on the first EXPOSE cycle
//   frame_done            1-cycle pulse on the last READOUT cycle
//   busy                  high in every state except IDLE
module line_frame_sequencer
    import sensor_pkg::*;
#(
    parameter int PIXELS     = PIXELS_DEF,
    parameter int PIX_DIV    = PIX_DIV_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int LEN_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [LEN_W-1:0]          exposure_len,
    input  logic [LEN_W-1:0]          laser_len,
    output logic                      sens_clk,
    output logic                      adc_clk,
    output logic                      exposure,
    output logic                      laser,
    output logic                      data_valid,
    output logic [$clog2(PIXELS)-1:0] pixel_addr,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    // The counters hold the latched lengths as "cycles remaining after this one",
    // so later changes on exposure_len/laser_len cannot affect a running frame.
    logic [LEN_W-1:0]  exp_cnt_q;
    logic [LEN_W-1:0]  exp_cnt_d;
    logic [LEN_W-1:0]  las_cnt_q;
    logic [LEN_W-1:0]  las_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_d;
    logic              exposure_d;
    logic              laser_d;
    logic              frame_start_d;
    logic              start_frame;
    logic              run_d;
    logic [LEN_W-1:0]  exp_eff;

    assign exp_eff = (exposure_len == '0) ? LEN_W'(1) : exposure_len;

    always_comb begin
        state_d       = state_q;
        exp_cnt_d     = exp_cnt_q;
        las_cnt_d     = las_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        exposure_d    = 1'b0;
        laser_d       = 1'b0;
        frame_start_d = 1'b0;
        start_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                end
            end
            EXPOSE: begin
                if (exp_cnt_q == '0) begin
                    // Last exposure cycle: laser drops with exposure whatever its count.
                    state_d = READOUT;
                end else begin
                    exposure_d = 1'b1;
                    exp_cnt_d  = exp_cnt_q - LEN_W'(1);
                    if (laser && (las_cnt_q != '0)) begin
                        laser_d   = 1'b1;
                        las_cnt_d = las_cnt_q - LEN_W'(1);
                    end
                end
            end
            READOUT: begin
                // frame_done is the registered "this is the final readout cycle" flag.
                if (frame_done) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            state_d       = EXPOSE;
            exp_cnt_d     = exp_eff - LEN_W'(1);
            las_cnt_d     = (laser_len == '0) ? '0 : (laser_len - LEN_W'(1));
            exposure_d    = 1'b1;
            laser_d       = (laser_len != '0);
            frame_start_d = 1'b1;
        end
    end

    assign run_d = (state_d == READOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_cnt_q   <= '0;
            las_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            exposure    <= 1'b0;
            laser       <= 1'b0;
            frame_start <= 1'b0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_cnt_q   <= exp_cnt_d;
            las_cnt_q   <= las_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            exposure    <= exposure_d;
            laser       <= laser_d;
            frame_start <= frame_start_d;
            data_valid  <= run_d;
            busy        <= (state_d != IDLE);
        end
    end

    pixel_clock_gen #(
        .PIXELS  (PIXELS),
        .PIX_DIV (PIX_DIV)
    ) u_pixel_clock_gen (
        .clk        (clk),
        .reset      (reset),
        .run_d      (run_d),
        .sens_clk   (sens_clk),
        .adc_clk    (adc_clk),
        .pixel_addr (pixel_addr),
        .frame_last (frame_done)
    );

endmodule

// File: tb/tb_line_frame_sequencer.sv
// tb/tb_line_frame_sequencer.sv - directed self-checking bench for line_frame_sequencer
module tb_line_frame_sequencer;
    import sensor_pkg::*;

    localparam int ADDR_W  = $clog2(PIXELS_DEF);
    localparam int RD_CYC  = PIXELS_DEF * PIX_DIV_DEF;   // 2048
    localparam int GAP_CYC = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0]       exposure_len;
    logic [15:0]       laser_len;
    logic              sens_clk, adc_clk, exposure, laser, data_valid;
    logic [ADDR_W-1:0] pixel_addr;
    logic              frame_start, frame_done, busy;

    line_frame_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .exposure_len (exposure_len),
        .laser_len    (laser_len),
        .sens_clk     (sens_clk),
        .adc_clk      (adc_clk),
        .exposure     (exposure),
        .laser        (laser),
        .data_valid   (data_valid),
        .pixel_addr   (pixel_addr),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Bench ADC model: injects a small peak at pixels 101..103 inside the valid window.
    logic [9:0] pix_data;
    always_comb begin
        pix_data = 10'd0;
        if (data_valid) begin
            if (pixel_addr == ADDR_W'(101)) pix_data = 10'd500;
            if (pixel_addr == ADDR_W'(102)) pix_data = 10'd800;
            if (pixel_addr == ADDR_W'(103)) pix_data = 10'd500;
        end
    end

    int checks = 0;
    int errors = 0;

    int cyc;
    int n_dv, n_rise, n_done, n_fs, n_busy, n_gap, addr_err, dv_bad;
    int exp_run, las_run, exp_first, exp_last, las_first, las_last;
    int exp_runs[$];
    int las_runs[$];
    int fs_pos[$];
    int cap[0:PIXELS_DEF-1];
    logic p_exp, p_las, p_sens;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        cyc = 0; n_dv = 0; n_rise = 0; n_done = 0; n_fs = 0; n_busy = 0; n_gap = 0;
        addr_err = 0; dv_bad = 0; exp_run = 0; las_run = 0;
        exp_first = -1; exp_last = -1; las_first = -1; las_last = -1;
        exp_runs.delete(); las_runs.delete(); fs_pos.delete();
        for (int i = 0; i < PIXELS_DEF; i++) cap[i] = 0;
        p_exp = 1'b0; p_las = 1'b0; p_sens = 1'b0;
    endtask

    task automatic sample();
        if (exposure) begin
            if (!p_exp) exp_first = cyc;
            exp_run++; exp_last = cyc;
        end else if (p_exp) begin
            exp_runs.push_back(exp_run); exp_run = 0;
        end
        if (laser) begin
            if (!p_las) las_first = cyc;
            las_run++; las_last = cyc;
        end else if (p_las) begin
            las_runs.push_back(las_run); las_run = 0;
        end
        if (data_valid) n_dv++;
        if ((sens_clk || adc_clk) && !data_valid) dv_bad++;
        if (data_valid && (exposure || laser)) dv_bad++;
        if (data_valid && (adc_clk === sens_clk)) dv_bad++;
        if (sens_clk && !p_sens) begin
            if (pixel_addr !== ADDR_W'(n_rise)) addr_err++;
            if (data_valid) cap[pixel_addr] = int'(pix_data);
            n_rise++;
        end
        if (frame_done) n_done++;
        if (frame_start) begin n_fs++; fs_pos.push_back(cyc); end
        if (busy) n_busy++;
        if (busy && !exposure && !data_valid) n_gap++;
        p_exp = exposure; p_las = laser; p_sens = sens_clk;
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin tick(); sample(); end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(); sample(); n++; end
        checks++;
        if (busy) begin errors++; $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n); end
    endtask

    // Start one frame with enable pulsed for a single cycle.
    task automatic start_single(input int exp_len, input int las_len);
        exposure_len = 16'(exp_len);
        laser_len    = 16'(las_len);
        enable       = 1'b1;
        tick();
        enable       = 1'b0;
        clear_stats();
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_entry: got %0b, required 1", frame_start); end
        sample();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; exposure_len = '0; laser_len = '0;
        tick(); tick();
        checks++;
        if ({sens_clk, adc_clk, exposure, laser, data_valid, frame_start, frame_done, busy} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b, required 00000000",
                {sens_clk, adc_clk, exposure, laser, data_valid, frame_start, frame_done, busy});
        end
        checks++;
        if (pixel_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", pixel_addr); end
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_enable: busy=%0b, required 0", busy); end
    endtask

    task automatic test_single_frame();
        start_single(100, 40);
        run_until_idle(5000);
        checks++;
        if (exp_runs.size() != 1 || exp_runs[0] != 100) begin errors++; $display("FAIL sf_exposure_len: runs=%0d first=%0d, required 1 run of 100", exp_runs.size(), (exp_runs.size() > 0) ? exp_runs[0] : -1); end
        checks++;
        if (las_runs.size() != 1 || las_runs[0] != 40) begin errors++; $display("FAIL sf_laser_len: runs=%0d first=%0d, required 1 run of 40", las_runs.size(), (las_runs.size() > 0) ? las_runs[0] : -1); end
        checks++;
        if (las_first != exp_first || exp_first != 0) begin errors++; $display("FAIL sf_laser_start: laser %0d exposure %0d, required both 0", las_first, exp_first); end
        checks++;
        if (n_dv != RD_CYC) begin errors++; $display("FAIL sf_data_valid: got %0d cycles, required %0d", n_dv, RD_CYC); end
        checks++;
        if (n_rise != PIXELS_DEF) begin errors++; $display("FAIL sf_sens_rises: got %0d, required %0d", n_rise, PIXELS_DEF); end
        checks++;
        if (addr_err != 0) begin errors++; $display("FAIL sf_pixel_addr: %0d wrong addresses at sens_clk rise, required 0", addr_err); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL sf_frame_done: got %0d pulses, required 1", n_done); end
        checks++;
        if (n_gap != GAP_CYC) begin errors++; $display("FAIL sf_gap: got %0d cycles, required %0d", n_gap, GAP_CYC); end
        checks++;
        if (n_busy != 100 + RD_CYC + GAP_CYC) begin errors++; $display("FAIL sf_busy: got %0d cycles, required %0d", n_busy, 100 + RD_CYC + GAP_CYC); end
        checks++;
        if (dv_bad != 0) begin errors++; $display("FAIL sf_window: %0d cycles with clocks/valid outside readout, required 0", dv_bad); end
        checks++;
        if (cap[101] != 500 || cap[102] != 800 || cap[103] != 500) begin
            errors++; $display("FAIL pixel_stream: got %0d/%0d/%0d, required 500/800/500", cap[101], cap[102], cap[103]);
        end
        checks++;
        if (cap[100] != 0 || cap[104] != 0) begin errors++; $display("FAIL pixel_stream_edges: got %0d/%0d, required 0/0", cap[100], cap[104]); end
    endtask

    task automatic test_laser_limits();
        start_single(100, 300);
        run_until_idle(5000);
        checks++;
        if (las_runs.size() != 1 || las_runs[0] != 100) begin errors++; $display("FAIL laser_clip_len: runs=%0d first=%0d, required 1 run of 100", las_runs.size(), (las_runs.size() > 0) ? las_runs[0] : -1); end
        checks++;
        if (las_last != exp_last) begin errors++; $display("FAIL laser_clip_end: laser ends %0d, required %0d", las_last, exp_last); end
        start_single(100, 0);
        run_until_idle(5000);
        checks++;
        if (las_first != -1) begin errors++; $display("FAIL laser_zero: laser first high at %0d, required never", las_first); end
        checks++;
        if (exp_runs.size() != 1 || exp_runs[0] != 100) begin errors++; $display("FAIL laser_zero_exposure: first=%0d, required 100", (exp_runs.size() > 0) ? exp_runs[0] : -1); end
    endtask

    task automatic test_exposure_zero();
        start_single(0, 0);
        run_until_idle(5000);
        checks++;
        if (exp_runs.size() != 1 || exp_runs[0] != 1) begin errors++; $display("FAIL exp_zero_len: runs=%0d first=%0d, required 1 run of 1", exp_runs.size(), (exp_runs.size() > 0) ? exp_runs[0] : -1); end
        checks++;
        if (n_dv != RD_CYC || n_done != 1) begin errors++; $display("FAIL exp_zero_readout: valid=%0d done=%0d, required %0d and 1", n_dv, n_done, RD_CYC); end
    endtask

    task automatic test_back_to_back();
        exposure_len = 16'd100;
        laser_len    = 16'd10;
        enable       = 1'b1;
        tick();
        clear_stats();
        sample();
        run_cycles(50);
        exposure_len = 16'd200;             // mid-frame change, must wait for frame 2
        run_cycles((100 + RD_CYC + GAP_CYC) + (200 + RD_CYC + GAP_CYC) + 10 - 50);
        enable = 1'b0;
        run_until_idle(5000);
        checks++;
        if (fs_pos.size() != 3) begin errors++; $display("FAIL b2b_frames: got %0d frame starts, required 3", fs_pos.size()); end
        checks++;
        if (fs_pos.size() >= 2 && fs_pos[1] - fs_pos[0] != 100 + RD_CYC + GAP_CYC) begin errors++; $display("FAIL b2b_spacing1: got %0d, required %0d", fs_pos[1] - fs_pos[0], 100 + RD_CYC + GAP_CYC); end
        checks++;
        if (fs_pos.size() >= 3 && fs_pos[2] - fs_pos[1] != 200 + RD_CYC + GAP_CYC) begin errors++; $display("FAIL b2b_spacing2: got %0d, required %0d", fs_pos[2] - fs_pos[1], 200 + RD_CYC + GAP_CYC); end
        checks++;
        if (exp_runs.size() != 3 || exp_runs[0] != 100 || exp_runs[1] != 200 || exp_runs[2] != 200) begin
            errors++; $display("FAIL b2b_exposure: runs=%0d first=%0d second=%0d, required 100/200/200", exp_runs.size(),
                (exp_runs.size() > 0) ? exp_runs[0] : -1, (exp_runs.size() > 1) ? exp_runs[1] : -1);
        end
        checks++;
        if (n_done != 3 || dv_bad != 0) begin errors++; $display("FAIL b2b_done: done=%0d bad=%0d, required 3 and 0", n_done, dv_bad); end
    endtask

    task automatic test_reset_mid_readout();
        int n;
        start_single(10, 0);
        n = 0;
        while (pixel_addr !== ADDR_W'(200) && n < 2000) begin tick(); n++; end
        checks++;
        if (pixel_addr !== ADDR_W'(200)) begin errors++; $display("FAIL rst_mid_reach: pixel_addr=%0d, required 200", pixel_addr); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sens_clk, adc_clk, exposure, laser, data_valid, frame_start, frame_done, busy} !== 8'h00 || pixel_addr !== '0) begin
            errors++; $display("FAIL rst_mid_async: outputs=%b addr=%0d, required 0",
                {sens_clk, adc_clk, exposure, laser, data_valid, frame_start, frame_done, busy}, pixel_addr);
        end
        tick(); tick();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: done=%0b busy=%0b, required 0/0", frame_done, busy); end
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        clear_stats();
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart: frame_start=%0b, required 1", frame_start); end
        sample();
        run_until_idle(5000);
        checks++;
        if (n_rise != PIXELS_DEF || addr_err != 0) begin errors++; $display("FAIL rst_restart_addr: rises=%0d addr_err=%0d, required %0d and 0", n_rise, addr_err, PIXELS_DEF); end
        checks++;
        if (n_done != 1 || exp_runs.size() != 1 || exp_runs[0] != 10) begin errors++; $display("FAIL rst_restart_frame: done=%0d exp=%0d, required 1 and 10", n_done, (exp_runs.size() > 0) ? exp_runs[0] : -1); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_laser_limits();
        test_exposure_zero();
        test_back_to_back();
        test_reset_mid_readout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
